// File: rtl/bicubic_pkg.sv
// Shared types and helpers for the bicubic resize sequencer.
package bicubic_pkg;

    localparam int IMG_W      = 100;
    localparam int SRAM_PITCH = 128;

    typedef enum logic [2:0] {
        IDLE,
        START,
        FETCH,
        DRAIN,
        WAIT_RES,
        WRITE,
        NEXT,
        FIN
    } ctrl_state_t;

    // {row[1:0], col[1:0]} of a tap inside the 4x4 window
    typedef logic [3:0] tap_idx_t;

    // Clamp a signed window coordinate into 0..hi
    function automatic logic [4:0] clamp(input logic signed [7:0] v, input logic [4:0] hi);
        if (v < 0)
            return 5'd0;
        else if (v > $signed({3'b000, hi}))
            return hi;
        else
            return v[4:0];
    endfunction

    // row * 100 as 64 + 32 + 4 shifts; the ImgROM pitch is fixed at 100
    function automatic logic [13:0] img_row_base(input logic [7:0] row);
        logic [15:0] r;
        r = {8'd0, row};
        return 14'((r << 6) + (r << 5) + (r << 2));
    endfunction

endpackage

// File: rtl/bicubic_dda.sv
// One axis of the source-position DDA: integer index plus remainder.
// The remainder stays below den, and step_amt <= den, so one carry per step suffices.
module bicubic_dda (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clear,
    input  logic       step,
    input  logic [4:0] step_amt,
    input  logic [5:0] den,
    output logic [4:0] pos,
    output logic [5:0] rem
);

    logic [6:0] sum;

    assign sum = {1'b0, rem} + {2'b00, step_amt};

    // Advance the remainder by step_amt, carrying into pos when it reaches den
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos <= '0;
            rem <= '0;
        end else if (clear) begin
            pos <= '0;
            rem <= '0;
        end else if (step) begin
            if (sum >= {1'b0, den}) begin
                rem <= 6'(sum - {1'b0, den});
                pos <= pos + 5'd1;
            end else begin
                rem <= sum[5:0];
            end
        end
    end

endmodule

// File: rtl/bicubic_scan_ctrl.sv
// Bicubic resize sequencer: walks target pixels row-major, fetches the 4x4
// source window from ImgROM, streams taps to the interpolation datapath and
// writes each result to ResultSRAM. A new job starts automatically after each.
// Optional build macro BICUBIC_EXACT_SKIP_EN: pixels landing exactly on a
// source sample fetch one tap and write rom_q directly, bypassing the datapath.
module bicubic_scan_ctrl
    import bicubic_pkg::*;
#(
    parameter int ROM_LAT = 1,
    parameter int DATA_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [6:0]        H0,
    input  logic [6:0]        V0,
    input  logic [4:0]        SW,
    input  logic [4:0]        SH,
    input  logic [5:0]        TW,
    input  logic [5:0]        TH,
    output logic [13:0]       rom_a,
    input  logic [DATA_W-1:0] rom_q,
    output logic              tap_valid,
    output logic [DATA_W-1:0] tap_data,
    output logic [3:0]        tap_idx,
    output logic [5:0]        fx_num,
    output logic [5:0]        fy_num,
    output logic [5:0]        fx_den,
    output logic [5:0]        fy_den,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic [13:0]       sram_a,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_wen,
    output logic              DONE
);

    // Last DRAIN count: full window waits out the ROM latency; the single
    // exact-hit tap also needs the cycle in which rom_q is captured.
    localparam logic [3:0] DRAIN_TAPS = 4'(ROM_LAT - 1);
    localparam logic [3:0] DRAIN_SKIP = 4'(ROM_LAT);

    ctrl_state_t state;

    logic [6:0]  h0_r, v0_r;
    logic [4:0]  sw_r, sh_r;
    logic [5:0]  tw_r, th_r;
    logic [5:0]  tx, ty;
    tap_idx_t    tap_k;
    logic [3:0]  drain_cnt;

    logic [4:0]  xi, yi;
    logic [5:0]  rx, ry;
    logic        x_clear, x_step, y_clear, y_step;
    logic        last_col, last_row, exact;

    logic [1:0]  tr, tc;
    logic [4:0]  sx, sy;
    logic [13:0] tap_addr, pix_addr;

    logic [ROM_LAT:0]           vld_p;
    tap_idx_t [ROM_LAT:0]       idx_p;

    assign last_col = (tx == tw_r - 6'd1);
    assign last_row = (ty == th_r - 6'd1);

`ifdef BICUBIC_EXACT_SKIP_EN
    assign exact = (rx == 6'd0) && (ry == 6'd0);
`else
    assign exact = 1'b0;
`endif

    // An exact hit fetches only the centre sample (r=1,c=1 maps to (yi,xi))
    assign tr = exact ? 2'd1 : tap_k[3:2];
    assign tc = exact ? 2'd1 : tap_k[1:0];

    assign sx = clamp($signed({3'b000, xi}) + $signed({6'd0, tc}) - 8'sd1, sw_r - 5'd1);
    assign sy = clamp($signed({3'b000, yi}) + $signed({6'd0, tr}) - 8'sd1, sh_r - 5'd1);

    assign tap_addr = img_row_base({1'b0, v0_r} + {3'b000, sy}) + {7'd0, h0_r} + {9'd0, sx};
    assign pix_addr = 14'({8'd0, ty} * SRAM_PITCH) + {8'd0, tx};

    // DDA control: clear at job/row start, step x per column, y per row
    always_comb begin
        x_clear = 1'b0;
        x_step  = 1'b0;
        y_clear = 1'b0;
        y_step  = 1'b0;
        if (state == START) begin
            x_clear = 1'b1;
            y_clear = 1'b1;
        end else if (state == NEXT) begin
            if (last_col) begin
                x_clear = 1'b1;
                y_step  = !last_row;
            end else begin
                x_step  = 1'b1;
            end
        end
    end

    bicubic_dda u_dda_x (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (x_clear),
        .step     (x_step),
        .step_amt (sw_r - 5'd1),
        .den      (fx_den),
        .pos      (xi),
        .rem      (rx)
    );

    bicubic_dda u_dda_y (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (y_clear),
        .step     (y_step),
        .step_amt (sh_r - 5'd1),
        .den      (fy_den),
        .pos      (yi),
        .rem      (ry)
    );

    assign fx_num = rx;
    assign fy_num = ry;

    // Main sequencer: job start, window fetch, result wait, SRAM write, DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            h0_r      <= '0;
            v0_r      <= '0;
            sw_r      <= '0;
            sh_r      <= '0;
            tw_r      <= '0;
            th_r      <= '0;
            fx_den    <= '0;
            fy_den    <= '0;
            tx        <= '0;
            ty        <= '0;
            tap_k     <= '0;
            drain_cnt <= '0;
            rom_a     <= '0;
            sram_a    <= '0;
            sram_d    <= '0;
            sram_wen  <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= START;
                end
                START: begin
                    h0_r   <= H0;
                    v0_r   <= V0;
                    sw_r   <= SW;
                    sh_r   <= SH;
                    tw_r   <= TW;
                    th_r   <= TH;
                    fx_den <= TW - 6'd1;
                    fy_den <= TH - 6'd1;
                    tx     <= '0;
                    ty     <= '0;
                    tap_k  <= '0;
                    state  <= FETCH;
                end
                FETCH: begin
                    rom_a     <= tap_addr;
                    drain_cnt <= '0;
                    if (exact || tap_k == 4'd15) begin
                        tap_k <= '0;
                        state <= DRAIN;
                    end else begin
                        tap_k <= tap_k + 4'd1;
                    end
                end
                DRAIN: begin
                    if (exact && drain_cnt == DRAIN_SKIP) begin
                        sram_wen <= 1'b1;
                        sram_a   <= pix_addr;
                        sram_d   <= rom_q;
                        state    <= WRITE;
                    end else if (!exact && drain_cnt == DRAIN_TAPS) begin
                        state <= WAIT_RES;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        sram_wen <= 1'b1;
                        sram_a   <= pix_addr;
                        sram_d   <= res_data;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    sram_wen <= 1'b0;
                    state    <= NEXT;
                end
                NEXT: begin
                    if (last_col && last_row) begin
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else if (last_col) begin
                        tx    <= '0;
                        ty    <= ty + 6'd1;
                        state <= FETCH;
                    end else begin
                        tx    <= tx + 6'd1;
                        state <= FETCH;
                    end
                end
                FIN: begin
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tap valid/index delay line: stage 0 aligns with rom_a, last stage with rom_q
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p <= '0;
            idx_p <= '0;
        end else begin
            vld_p <= {vld_p[ROM_LAT-1:0], (state == FETCH) && !exact};
            idx_p <= {idx_p[ROM_LAT-1:0], tap_k};
        end
    end

    assign tap_valid = vld_p[ROM_LAT];
    assign tap_idx   = idx_p[ROM_LAT];
    assign tap_data  = tap_valid ? rom_q : '0;

endmodule

// File: tb/tb_bicubic_scan_ctrl.sv
// Self-checking bench for bicubic_scan_ctrl: ImgROM and echo-tap-5 datapath
// models, closed-form DDA reference, scoreboard on taps, writes and DONE.
module tb_bicubic_scan_ctrl;
    import bicubic_pkg::IMG_W;
    import bicubic_pkg::SRAM_PITCH;

    localparam int NJOBS = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  H0, V0;
    logic [4:0]  SW, SH;
    logic [5:0]  TW, TH;
    logic [13:0] rom_a;
    logic [7:0]  rom_q;
    logic        tap_valid;
    logic [7:0]  tap_data;
    logic [3:0]  tap_idx;
    logic [5:0]  fx_num, fy_num, fx_den, fy_den;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [13:0] sram_a;
    logic [7:0]  sram_d;
    logic        sram_wen;
    logic        DONE;

    int n_chk = 0;
    int n_err = 0;

    int cfg_h0[NJOBS], cfg_v0[NJOBS], cfg_sw[NJOBS], cfg_sh[NJOBS], cfg_tw[NJOBS], cfg_th[NJOBS];
    int c_h0, c_v0, c_sw, c_sh, c_tw, c_th;
    int pix, tcnt, low_cnt, pcyc, job;
    logic [13:0] prev_rom_a;
    bit done_seen, rst_done;

    logic [3:0] dp_cnt;
    int         dp_wait;
    logic [7:0] dp_keep;

    bicubic_scan_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .H0        (H0),
        .V0        (V0),
        .SW        (SW),
        .SH        (SH),
        .TW        (TW),
        .TH        (TH),
        .rom_a     (rom_a),
        .rom_q     (rom_q),
        .tap_valid (tap_valid),
        .tap_data  (tap_data),
        .tap_idx   (tap_idx),
        .fx_num    (fx_num),
        .fy_num    (fy_num),
        .fx_den    (fx_den),
        .fy_den    (fy_den),
        .res_valid (res_valid),
        .res_data  (res_data),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_wen  (sram_wen),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_fn(input int a);
        int h;
        h = a * 37 + (a >> 5);
        return 8'(h ^ 'h5A);
    endfunction

    // One-cycle-latency ImgROM
    always @(posedge CLK) rom_q <= rom_fn(int'(rom_a));

    // Datapath: echoes tap 5 a few cycles after the 16th tap; also emits a
    // decoy res_valid early in the window, which must be ignored.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            dp_cnt    <= '0;
            dp_wait   <= 0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= 1'b0;
            if (dp_wait != 0) begin
                if (dp_wait == 1) begin
                    res_valid <= 1'b1;
                    res_data  <= dp_keep;
                end
                dp_wait <= dp_wait - 1;
            end
            if (tap_valid) begin
                if (tap_idx == 4'd5) dp_keep <= tap_data;
                if (tap_idx == 4'd3) begin
                    res_valid <= 1'b1;
                    res_data  <= 8'hEE;
                end
                if (dp_cnt == 4'd15) begin
                    dp_cnt  <= '0;
                    dp_wait <= int'($urandom_range(1, 4));
                end else begin
                    dp_cnt <= dp_cnt + 4'd1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: position of target index t is t*(S-1)/(T-1), remainder the modulus
    function automatic int dda_pos(input int t, input int s, input int n);
        return (t * (s - 1)) / (n - 1);
    endfunction

    function automatic int dda_rem(input int t, input int s, input int n);
        return (t * (s - 1)) % (n - 1);
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int exp_tap_addr(input int tx, input int ty, input int k);
        int sx, sy;
        sx = clampi(dda_pos(tx, c_sw, c_tw) + (k % 4) - 1, c_sw - 1);
        sy = clampi(dda_pos(ty, c_sh, c_th) + (k / 4) - 1, c_sh - 1);
        return (c_v0 + sy) * IMG_W + c_h0 + sx;
    endfunction

    function automatic bit exp_exact(input int tx, input int ty);
`ifdef BICUBIC_EXACT_SKIP_EN
        return dda_rem(tx, c_sw, c_tw) == 0 && dda_rem(ty, c_sh, c_th) == 0;
`else
        return (tx < 0) && (ty < 0);
`endif
    endfunction

    task automatic load_cfg(input int j);
        c_h0 = cfg_h0[j]; c_v0 = cfg_v0[j]; c_sw = cfg_sw[j];
        c_sh = cfg_sh[j]; c_tw = cfg_tw[j]; c_th = cfg_th[j];
        H0 = 7'(c_h0); V0 = 7'(c_v0); SW = 5'(c_sw);
        SH = 5'(c_sh); TW = 6'(c_tw); TH = 6'(c_th);
    endtask

    task automatic check_outputs_zero(input string pfx);
        chk({pfx, "_rom_a"},     rom_a, 0);
        chk({pfx, "_tap_valid"}, tap_valid, 0);
        chk({pfx, "_tap_data"},  tap_data, 0);
        chk({pfx, "_tap_idx"},   tap_idx, 0);
        chk({pfx, "_fx_num"},    fx_num, 0);
        chk({pfx, "_fy_num"},    fy_num, 0);
        chk({pfx, "_fx_den"},    fx_den, 0);
        chk({pfx, "_fy_den"},    fy_den, 0);
        chk({pfx, "_sram_a"},    sram_a, 0);
        chk({pfx, "_sram_d"},    sram_d, 0);
        chk({pfx, "_sram_wen"},  sram_wen, 0);
        chk({pfx, "_DONE"},      DONE, 0);
    endtask

    task automatic mon_cycle();
        int tx, ty, ea;
        done_seen = 1'b0;
        tx = pix % c_tw;
        ty = pix / c_tw;
        pcyc++;
        if (tap_valid) begin
            ea = exp_tap_addr(tx, ty, tcnt);
            chk("tap_idx", tap_idx, tcnt);
            chk("rom_a", prev_rom_a, ea);
            chk("tap_data", tap_data, rom_fn(ea));
            chk("fx_num", fx_num, dda_rem(tx, c_sw, c_tw));
            chk("fy_num", fy_num, dda_rem(ty, c_sh, c_th));
            chk("fx_den", fx_den, c_tw - 1);
            chk("fy_den", fy_den, c_th - 1);
            tcnt++;
        end
        if (sram_wen) begin
            chk("wen_in_job", pix < c_tw * c_th, 1);
            chk("sram_a", sram_a, ty * SRAM_PITCH + tx);
            chk("sram_d", sram_d, rom_fn(exp_tap_addr(tx, ty, 5)));
            chk("tap_count", tcnt, exp_exact(tx, ty) ? 0 : 16);
            pix++;
            tcnt = 0;
            pcyc = 0;
        end
        if (DONE) begin
            chk("done_pixels", pix, c_tw * c_th);
            chk("done_gap", low_cnt >= 2, 1);
            low_cnt   = 0;
            pix       = 0;
            tcnt      = 0;
            done_seen = 1'b1;
        end else begin
            low_cnt++;
        end
        prev_rom_a = rom_a;
    endtask

    initial begin
        // Directed configurations followed by random ones
        cfg_h0[0] = 0;  cfg_v0[0] = 0;  cfg_sw[0] = 2;  cfg_sh[0] = 2; cfg_tw[0] = 3;  cfg_th[0] = 3;
        cfg_h0[1] = 98; cfg_v0[1] = 98; cfg_sw[1] = 2;  cfg_sh[1] = 2; cfg_tw[1] = 2;  cfg_th[1] = 2;
        cfg_h0[2] = 10; cfg_v0[2] = 20; cfg_sw[2] = 5;  cfg_sh[2] = 2; cfg_tw[2] = 9;  cfg_th[2] = 2;
        cfg_h0[3] = 0;  cfg_v0[3] = 0;  cfg_sw[3] = 3;  cfg_sh[3] = 2; cfg_tw[3] = 5;  cfg_th[3] = 3;
        cfg_h0[4] = 69; cfg_v0[4] = 50; cfg_sw[4] = 31; cfg_sh[4] = 2; cfg_tw[4] = 33; cfg_th[4] = 2;
        for (int j = 5; j < NJOBS; j++) begin
            cfg_sw[j] = int'($urandom_range(2, 7));
            cfg_sh[j] = int'($urandom_range(2, 7));
            cfg_tw[j] = cfg_sw[j] + int'($urandom_range(0, 5));
            cfg_th[j] = cfg_sh[j] + int'($urandom_range(0, 5));
            cfg_h0[j] = int'($urandom_range(0, 100 - cfg_sw[j]));
            cfg_v0[j] = int'($urandom_range(0, 100 - cfg_sh[j]));
        end

        RST = 1'b1;
        load_cfg(0);
        pix = 0; tcnt = 0; low_cnt = 100; pcyc = 0; job = 0;
        prev_rom_a = '0; rst_done = 1'b0; done_seen = 1'b0;

        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RST = 1'b0;

        for (int cyc = 0; cyc < 60000 && job < NJOBS; cyc++) begin
            @(negedge CLK);
            mon_cycle();
            if (done_seen) begin
                job++;
                if (job < NJOBS) load_cfg(job);
            end else if (job == 1 && !rst_done && pix == 3 && pcyc == 4) begin
                RST = 1'b1;
                #1;
                check_outputs_zero("midrst");
                @(negedge CLK);
                chk("midrst_hold_wen", sram_wen, 0);
                RST = 1'b0;
                pix = 0; tcnt = 0; pcyc = 0; low_cnt = 100;
                prev_rom_a = rom_a;
                rst_done = 1'b1;
            end
        end

        chk("jobs_completed", job, NJOBS);
        chk("reset_exercised", rst_done, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
